// File: rtl/seq_mod_div.sv
// seq_mod_div: multi-cycle restoring divider producing quotient and remainder of two DATAWIDTH-bit operands.
// Latency: DATAWIDTH edges from accepted start to DONE (DATAWIDTH+1 with MOD_SIGNED_EN); divide-by-zero takes one edge.
// Handshake: start is accepted only in IDLE or DONE and ignored while busy; done pulses for one cycle.
// Optional build macro: MOD_SIGNED_EN (two's-complement operands, extra FIX state applies result signs).
module seq_mod_div #(
   parameter int DATAWIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic [DATAWIDTH-1:0] quot,
   output logic [DATAWIDTH-1:0] rem,
   output logic                 busy,
   output logic                 done,
   output logic                 dz
);

   localparam int            CW       = $clog2(DATAWIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(DATAWIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
`ifdef MOD_SIGNED_EN
      , S_FIX = 2'd3
`endif
   } state_t;

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   // dvd_q starts as the dividend and fills with quotient bits from the right as it shifts.
   logic [DATAWIDTH-1:0] dvd_q;
   logic [DATAWIDTH-1:0] dvs_q;
   logic [DATAWIDTH:0]   prem_q;
   logic [DATAWIDTH-1:0] quot_q;
   logic [DATAWIDTH-1:0] rem_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 dz_q;
`ifdef MOD_SIGNED_EN
   logic                 sign_a_q;
   logic                 neg_quot_q;
   logic [DATAWIDTH-1:0] quot_fix;
   logic [DATAWIDTH-1:0] rem_fix;
`endif

   // Combinational step values: one restoring shift-subtract iteration and operand magnitudes.
   logic [DATAWIDTH+1:0] shift_rem;
   logic [DATAWIDTH+1:0] trial;
   logic                 q_bit;
   logic [DATAWIDTH:0]   prem_d;
   logic [DATAWIDTH-1:0] dvd_d;
   logic [DATAWIDTH-1:0] a_mag;
   logic [DATAWIDTH-1:0] b_mag;

   // One quotient bit per cycle: shift the next dividend bit in, keep the difference if non-negative.
   always_comb begin
      shift_rem = {prem_q, dvd_q[DATAWIDTH-1]};
      trial     = shift_rem - {2'b00, dvs_q};
      // The shifted remainder is below 2*divisor, so bit DATAWIDTH+1 is set only on a borrow.
      q_bit     = ~trial[DATAWIDTH+1];
      prem_d    = q_bit ? trial[DATAWIDTH:0] : shift_rem[DATAWIDTH:0];
      dvd_d     = {dvd_q[DATAWIDTH-2:0], q_bit};
   end

`ifdef MOD_SIGNED_EN
   // Operand magnitudes; the most-negative value maps to 2^(DATAWIDTH-1), which still fits unsigned.
   always_comb begin
      a_mag = a[DATAWIDTH-1] ? -a : a;
      b_mag = b[DATAWIDTH-1] ? -b : b;
   end

   // Sign correction applied in FIX: quotient negated on sign mismatch, remainder follows the dividend.
   always_comb begin
      quot_fix = neg_quot_q ? -dvd_q : dvd_q;
      rem_fix  = sign_a_q ? -prem_q[DATAWIDTH-1:0] : prem_q[DATAWIDTH-1:0];
   end
`else
   // Unsigned build divides the operands as given.
   always_comb begin
      a_mag = a;
      b_mag = b;
   end
`endif

   // Control FSM and datapath registers; all outputs come straight from flops.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         prem_q     <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dz_q       <= 1'b0;
`ifdef MOD_SIGNED_EN
         sign_a_q   <= 1'b0;
         neg_quot_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
`ifdef MOD_SIGNED_EN
                  sign_a_q   <= a[DATAWIDTH-1];
                  neg_quot_q <= a[DATAWIDTH-1] ^ b[DATAWIDTH-1];
`endif
                  if (b == '0) begin
                     // Divide-by-zero completes immediately with a saturated quotient.
                     dvd_q   <= a;
                     dvs_q   <= b;
                     prem_q  <= '0;
                     cnt_q   <= '0;
                     quot_q  <= '1;
                     rem_q   <= a;
                     dz_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     dvd_q   <= a_mag;
                     dvs_q   <= b_mag;
                     prem_q  <= '0;
                     cnt_q   <= CNT_INIT;
                     busy_q  <= 1'b1;
                     state_q <= S_CALC;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end

            S_CALC: begin
               prem_q <= prem_d;
               dvd_q  <= dvd_d;
               cnt_q  <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
`ifdef MOD_SIGNED_EN
                  // Magnitudes are final; signs are applied on the next edge.
                  state_q <= S_FIX;
`else
                  quot_q  <= dvd_d;
                  rem_q   <= prem_d[DATAWIDTH-1:0];
                  dz_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
`endif
               end
            end

`ifdef MOD_SIGNED_EN
            S_FIX: begin
               quot_q  <= quot_fix;
               rem_q   <= rem_fix;
               dz_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
`endif

            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign quot = quot_q;
   assign rem  = rem_q;
   assign busy = busy_q;
   assign done = done_q;
   assign dz   = dz_q;

endmodule
